shift_readout_ctrl: RTL

//   Sequences the WIDTH-bit one-hot shift_register that selects readout columns.
//   For each column i: injects a token, lets it shift i cycles, pulses load, then

---
 rtl/shift_readout_ctrl_if.sv | 21 ++
 rtl/shift_readout_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/shift_readout_ctrl_if.sv
// Column stream between the readout controller and the serializer.
// The controller drives the master side; the serializer drives the slave side.
interface shift_readout_ctrl_if #(
  parameter int IDX_W = 9
);
  logic [IDX_W-1:0] col_idx;
  logic             col_valid;
  logic             col_ready;

  modport master (
    output col_idx,
    output col_valid,
    input  col_ready
  );

  modport slave (
    input  col_idx,
    input  col_valid,
    output col_ready
  );
endinterface

// File: rtl/shift_readout_ctrl.sv
// Sequences a one-hot column-select shift chain and presents each column on a stream.
// Optional macro SCAN_CONTINUOUS_EN adds cfg_continuous for back-to-back frames.
module shift_readout_ctrl #(
  parameter int WIDTH = 512,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [IDX_W-1:0]     cfg_last,
`ifdef SCAN_CONTINUOUS_EN
  input  logic                 cfg_continuous,
`endif
  output logic                 sr_shift_in,
  output logic                 sr_load,
  output logic                 busy,
  output logic                 frame_done,
  shift_readout_ctrl_if.master col_if
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INJECT  = 3'd1,
    S_WAIT    = 3'd2,
    S_LOAD    = 3'd3,
    S_PRESENT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [IDX_W-1:0] LAST_MAX = IDX_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             sr_shift_in_q, sr_shift_in_d;
  logic             sr_load_q, sr_load_d;
  logic             col_valid_q, col_valid_d;
  logic [IDX_W-1:0] col_idx_q, col_idx_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;

  logic [IDX_W-1:0] cfg_last_clamped;
  logic             continue_scan;
  logic             wrap;

  assign cfg_last_clamped = (cfg_last > LAST_MAX) ? LAST_MAX : cfg_last;

`ifdef SCAN_CONTINUOUS_EN
  assign continue_scan = cfg_continuous;
`else
  assign continue_scan = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      last_q        <= '0;
      wait_cnt_q    <= '0;
      sr_shift_in_q <= 1'b0;
      sr_load_q     <= 1'b0;
      col_valid_q   <= 1'b0;
      col_idx_q     <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      last_q        <= last_d;
      wait_cnt_q    <= wait_cnt_d;
      sr_shift_in_q <= sr_shift_in_d;
      sr_load_q     <= sr_load_d;
      col_valid_q   <= col_valid_d;
      col_idx_q     <= col_idx_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
    end
  end

  // Abort wins over everything, including a start arriving while idle.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_d     = last_q;
    wait_cnt_d = wait_cnt_q;
    wrap       = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_INJECT;
            idx_d   = '0;
            last_d  = cfg_last_clamped;
          end
        end
        S_INJECT: begin
          wait_cnt_d = idx_q;
          state_d    = (idx_q != '0) ? S_WAIT : S_LOAD;
        end
        S_WAIT: begin
          wait_cnt_d = wait_cnt_q - 1'b1;
          if (wait_cnt_q <= IDX_W'(1)) begin
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          state_d = S_PRESENT;
        end
        S_PRESENT: begin
          if (col_valid_q && col_if.col_ready) begin
            if (idx_q == last_q) begin
              if (continue_scan) begin
                state_d = S_INJECT;
                idx_d   = '0;
                last_d  = cfg_last_clamped;
                wrap    = 1'b1;
              end else begin
                state_d = S_DONE;
              end
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_INJECT;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they leave the flops aligned with state_q.
  always_comb begin
    sr_shift_in_d = (state_d == S_INJECT);
    sr_load_d     = (state_d == S_LOAD);
    col_valid_d   = (state_d == S_PRESENT);
    col_idx_d     = (state_d == S_PRESENT) ? idx_d : '0;
    busy_d        = (state_d != S_IDLE);
    frame_done_d  = (state_d == S_DONE) || wrap;
  end

  assign sr_shift_in      = sr_shift_in_q;
  assign sr_load          = sr_load_q;
  assign busy             = busy_q;
  assign frame_done       = frame_done_q;
  assign col_if.col_valid = col_valid_q;
  assign col_if.col_idx   = col_idx_q;

endmodule
